// File: rtl/tow_pkg.sv
// tow_pkg: shared widths, taps, default seed and LFSR step for the Tug-of-War random source
package tow_pkg;
  localparam int RND_W  = 9;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;
  typedef logic [RND_W-1:0] rnd_t;
  localparam rnd_t DEF_SEED = 9'h1A5;
  function automatic rnd_t lfsr_next(input rnd_t r);
    return {r[RND_W-2:0], r[TAP_HI] ^ r[TAP_LO]};
  endfunction
endpackage

// File: rtl/tow_rand_gen_if.sv
// tow_rand_gen_if: control inputs and random outputs of the Tug-of-War random source
interface tow_rand_gen_if;
  import tow_pkg::*;
  logic enable;
  logic step_req;
  logic load;
  rnd_t seed_in;
  rnd_t rnd;
  logic rnd_valid;
  logic seed_err;
  modport master(output enable, step_req, load, seed_in, input rnd, rnd_valid, seed_err);
  modport slave(input enable, step_req, load, seed_in, output rnd, rnd_valid, seed_err);
endinterface

// File: rtl/tow_rand_gen_tick_div.sv
// tick_div: enable-gated prescaler that raises tick on its last count and wraps
module tick_div #(
  parameter int TICK_DIV = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = enable && (cnt_q == CW'(TICK_DIV - 1));
  always_comb begin
    cnt_d = cnt_q;
    cnt_d = (clear || tick) ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tow_rand_gen.sv
// tow_rand_gen: 9-bit x^9+x^5+1 LFSR stepped by prescaler tick or on demand, with seed load
module tow_rand_gen
  import tow_pkg::*;
#(
  parameter int   TICK_DIV = 512,
  parameter rnd_t SEED     = DEF_SEED
) (
  input logic clk,
  input logic reset,
  tow_rand_gen_if.slave bus
);
  rnd_t rnd_q, rnd_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic tick, step, seed_zero;
  tick_div #(.TICK_DIV(TICK_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .enable(bus.enable),
    .clear(bus.load),
    .tick(tick)
  );
  assign step      = tick || bus.step_req;
  assign seed_zero = (bus.seed_in == '0);
  // a zero state (upset) would lock the LFSR, so a step from zero reseeds instead
  always_comb begin
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rnd_d   = bus.load ? (seed_zero ? SEED : bus.seed_in)
            : step ? ((rnd_q == '0) ? SEED : lfsr_next(rnd_q))
            : rnd_q;
    valid_d = !bus.load && step;
    err_d   = bus.load && seed_zero;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rnd_q   <= SEED;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  assign bus.rnd       = rnd_q;
  assign bus.rnd_valid = valid_q;
  assign bus.seed_err  = err_q;
endmodule

// File: tb/tb_tow_rand_gen.sv
// tb_tow_rand_gen: directed checks of stepping, loading, prescaler pacing and reset
module tb_tow_rand_gen;
  import tow_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  tow_rand_gen_if bus();
  tow_rand_gen #(.TICK_DIV(4), .SEED(9'h1A5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic step_expect(input int idle, input int exp, input string tag);
    for (int i = 0; i < idle; i++) begin
      cyc();
      chk({tag, "_idle"}, int'(bus.rnd_valid), 0);
    end
    cyc();
    chk({tag, "_rnd"}, int'(bus.rnd), exp);
    chk({tag, "_vld"}, int'(bus.rnd_valid), 1);
  endtask
  initial begin
    int seq_exp [5] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
    bit seen [512];
    int seq_bad;
    bus.enable = 1'b0;
    bus.step_req = 1'b0;
    bus.load = 1'b0;
    bus.seed_in = '0;
    #12;
    chk("rst_rnd", int'(bus.rnd), 9'h1A5);
    chk("rst_vld", int'(bus.rnd_valid), 0);
    chk("rst_err", int'(bus.seed_err), 0);
    cyc();
    reset = 1'b0;
    bus.load = 1'b1;
    bus.seed_in = 9'h001;
    cyc();
    bus.load = 1'b0;
    chk("load1_rnd", int'(bus.rnd), 9'h001);
    chk("load1_vld", int'(bus.rnd_valid), 0);
    chk("load1_err", int'(bus.seed_err), 0);
    bus.step_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("seq%0d_rnd", i), int'(bus.rnd), seq_exp[i]);
      chk($sformatf("seq%0d_vld", i), int'(bus.rnd_valid), 1);
    end
    bus.step_req = 1'b0;
    cyc();
    chk("seq_vld_low", int'(bus.rnd_valid), 0);
    bus.load = 1'b1;
    bus.seed_in = 9'h001;
    cyc();
    bus.load = 1'b0;
    bus.step_req = 1'b1;
    seq_bad = 0;
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int i = 1; i <= 511; i++) begin
      cyc();
      if (bus.rnd == '0 || !bus.rnd_valid) seq_bad++;
      if (i < 511 && seen[bus.rnd]) seq_bad++;
      seen[bus.rnd] = 1'b1;
    end
    bus.step_req = 1'b0;
    chk("period_rnd", int'(bus.rnd), 9'h001);
    chk("period_clean", seq_bad, 0);
    bus.load = 1'b1;
    bus.seed_in = '0;
    cyc();
    bus.load = 1'b0;
    chk("zload_rnd", int'(bus.rnd), 9'h1A5);
    chk("zload_err", int'(bus.seed_err), 1);
    chk("zload_vld", int'(bus.rnd_valid), 0);
    cyc();
    chk("zload_err_once", int'(bus.seed_err), 0);
    bus.load = 1'b1;
    bus.seed_in = 9'h0AA;
    bus.step_req = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.step_req = 1'b0;
    chk("ldstep_rnd", int'(bus.rnd), 9'h0AA);
    chk("ldstep_vld", int'(bus.rnd_valid), 0);
    chk("ldstep_err", int'(bus.seed_err), 0);
    reset = 1'b1;
    bus.enable = 1'b1;
    #2;
    reset = 1'b0;
    step_expect(3, 9'h14B, "tick1");
    step_expect(3, 9'h097, "tick2");
    cyc();
    chk("pre_pause_vld", int'(bus.rnd_valid), 0);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_vld", int'(bus.rnd_valid), 0);
    end
    bus.enable = 1'b1;
    step_expect(2, 9'h12F, "resume");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("coin_idle", int'(bus.rnd_valid), 0);
    end
    bus.step_req = 1'b1;
    cyc();
    bus.step_req = 1'b0;
    chk("coin_rnd", int'(bus.rnd), 9'h05F);
    chk("coin_vld", int'(bus.rnd_valid), 1);
    step_expect(3, 9'h0BF, "coin_wrap");
    cyc();
    chk("mid_vld", int'(bus.rnd_valid), 0);
    bus.step_req = 1'b1;
    cyc();
    bus.step_req = 1'b0;
    chk("mid_rnd", int'(bus.rnd), 9'h17F);
    chk("mid_vld_hi", int'(bus.rnd_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rnd", int'(bus.rnd), 9'h1A5);
    chk("async_vld", int'(bus.rnd_valid), 0);
    chk("async_err", int'(bus.seed_err), 0);
    cyc();
    reset = 1'b0;
    step_expect(3, 9'h14B, "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tow_rand_gen.md
# tow_rand_gen

Pseudo-random source for the Tug-of-War player-vs-computer datapath. It produces a 9-bit maximal-length LFSR value that feeds the computer-side operand of the 9-bit compare adder; the adder's carry-out becomes the computer's press decision. Steps are paced by an internal prescaler and can also be requested on demand. A `rnd_valid` strobe marks each new value so downstream logic samples the carry once per step.

## Interface
- `TICK_DIV`, default 512: enabled clock cycles per automatic LFSR step, legal range ≥2.
- `SEED`, default 9'h1A5: reset value and zero-substitute seed, must be nonzero.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  prescaler runs while high; holds its count while low.
- `step_req`  in  1  single-cycle request for one immediate step, honoured regardless of `enable`.
- `load`  in  1  synchronous seed load.
- `seed_in`  in  9  value loaded when `load`=1.
- `rnd`  out  9  current LFSR state, which drives the adder's b operand.
- `rnd_valid`  out  1  one-cycle pulse: `rnd` changed by a step this cycle.
- `seed_err`  out  1  one-cycle pulse: `load` with `seed_in`=0 and `SEED` substituted.

## Operation
- LFSR: Fibonacci, polynomial x^9+x^5+1. A step is next = {rnd[7:0], rnd[8]^rnd[4]}. Period is 511 and the all-zero state is never entered.
- Prescaler `cnt` runs 0..TICK_DIV-1 and increments when `enable`=1. The tick condition is `enable`=1 and cnt==TICK_DIV-1; on tick, cnt wraps to 0.
- A step occurs when tick or `step_req` is high. If both are high in the same cycle, exactly one step occurs, and cnt still wraps.
- Priority: reset > load > step.
- Load: rnd ← (seed_in==0 ? SEED : seed_in) and cnt ← 0. `rnd_valid` stays 0 that cycle. `seed_err` pulses only for a zero seed. A step request or tick in the same cycle is discarded.
- Zero guard: if rnd is ever 0 (e.g. an SEU), the next step loads SEED instead of shifting and still pulses `rnd_valid`.
- Reset values: rnd=SEED, cnt=0, rnd_valid=0, seed_err=0.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- A step decided in cycle N makes `rnd` take the new value after edge N+1. `rnd_valid` is high for exactly the cycle after that edge.
- With `enable` held high from reset release, the first automatic step lands after TICK_DIV edges, then every TICK_DIV edges.
- Dropping `enable` freezes cnt, and resuming continues from the frozen count. `step_req` while disabled still steps but does not touch cnt.
- Back-to-back `step_req` produces one step per cycle, with `rnd_valid` high continuously.
- Reset asserted mid-count clears cnt and rnd immediately, with no completion of a pending step. The first tick after release takes a full TICK_DIV cycles.

## Structure
- Package `tow_pkg` holds:
  - `RND_W`=9
  - tap indices `TAP_HI`=8, `TAP_LO`=4
  - default seed constant 9'h1A5
  - typedef `rnd_t` = logic [RND_W-1:0]
- Sub-module `tick_div` contains the prescaler, with params TICK_DIV, inputs clk/reset/enable/clear, and output tick. The parent owns the LFSR, load/zero logic and strobes.

## Test plan
- Reset, then `load` seed_in=9'h001 with enable=0 → rnd=001. Five `step_req` pulses give 002, 004, 008, 010, 021, with `rnd_valid` high after each.
- TICK_DIV=4, enable=1 after reset → rnd steps from 1A5 once per 4 cycles and `rnd_valid` pulses every 4th cycle. Toggling enable low for 3 cycles mid-count delays the next step by exactly 3 cycles.
- Seed 9'h001, 511 consecutive steps → rnd returns to 001, with no intermediate 000 and no repeat before step 511.
- `load` with seed_in=0 → rnd=SEED, `seed_err` pulses once, `rnd_valid`=0. `load` and `step_req` in the same cycle → rnd=seed_in with no step.
- `step_req` coinciding with tick → exactly one step, one `rnd_valid`, and cnt restarts at 0.
- Assert reset for one cycle mid-count with cnt=2 → rnd=SEED and outputs 0 asynchronously, and the next tick arrives TICK_DIV cycles after release.
